// File: rtl/riscv_pipe_pkg.sv
// Shared RV32 pipeline definitions: data width, canonical NOP and the
// {pc, instr} entry carried from fetch towards decode.
package riscv_pipe_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0 -- what decode sees whenever fetch has nothing real
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Instruction-memory request/response bus between the prefetch unit (master)
// and the instruction memory (slave).
interface instr_prefetch_unit_if;
  import riscv_pipe_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and occupancy
// count; push and pop may coincide at any occupancy, including full.
module prefetch_fifo
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_count == '0);
  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push = push & (~w_full | w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values no matter how statements are ordered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; r_count alone says which slots
  // hold valid data, so the array needs no reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Credit-limited instruction prefetcher feeding decode, with redirect flush.
// Define PREFETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_prefetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_prefetch_unit_if.master imem,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  stall_d,
  output logic [XLEN-1:0]       instr_d,
  output logic [XLEN-1:0]       pc_d,
  output logic [XLEN-1:0]       pcplus4_d,
  output logic                  valid_d
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_in_use;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_keep;
  logic            w_bypass;
  logic            w_fifo_empty;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_head;
  fetch_entry_t    w_rsp_entry;

  // Every slot is either queued or still owed by memory; never promise more than DEPTH.
  assign w_in_use    = (CW+1)'(r_outstanding) + (CW+1)'(w_count);
  assign w_req_valid = rst & ~redirect_valid & (w_in_use < (CW+1)'(DEPTH));
  assign w_req_fire  = w_req_valid & imem.imem_req_ready;

  assign w_rsp_keep  = imem.imem_rsp_valid & ~redirect_valid & (r_discard == '0);
  assign w_rsp_entry = '{pc: r_rsp_pc, instr: imem.imem_rsp_data};

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = w_rsp_keep & w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = ~w_fifo_empty & ~stall_d & ~redirect_valid;
  // A bypassed word that decode takes right away never enters the queue.
  assign w_push = w_rsp_keep & ~(w_bypass & ~stall_d);

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_fetch_pc;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_rsp_entry),
    .rdata (w_head),
    .count (w_count),
    .empty (w_fifo_empty)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    valid_d = 1'b0;
    instr_d = NOP_INSTR;
    pc_d    = '0;
    if (w_bypass) begin
      valid_d = 1'b1;
      instr_d = w_rsp_entry.instr;
      pc_d    = w_rsp_entry.pc;
    end else if (!w_fifo_empty) begin
      valid_d = 1'b1;
      instr_d = w_head.instr;
      pc_d    = w_head.pc;
    end
  end

  assign pcplus4_d = pc_d + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_valid) begin
      // Responses still owed after this cycle belong to the old path; the one
      // arriving now is dropped immediately.
      r_fetch_pc    <= word_align(redirect_pc);
      r_rsp_pc      <= word_align(redirect_pc);
      r_outstanding <= r_outstanding - CW'(imem.imem_rsp_valid);
      r_discard     <= r_outstanding - CW'(imem.imem_rsp_valid);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + 32'd4;
      if (imem.imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem.imem_rsp_valid);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: stream-level model plus a
// latency-programmable in-order memory, with directed scenarios.
module tb_instr_prefetch_unit;
  import riscv_pipe_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  instr_prefetch_unit_if imem_bus ();

  instr_prefetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem_bus.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pcplus4_d      (pcplus4_d),
    .valid_d        (valid_d)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Contents of instruction memory at a given word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory + stream model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_rsp_t;

  mem_rsp_t    mem_q[$];
  int          mem_lat = 1;
  logic        nxt_v   = 1'b0;
  logic [31:0] nxt_d   = '0;

  int          cyc = 0;
  int          m_occ, m_inflight, m_discard;
  logic [31:0] m_fetch, m_dec;
  bit          e_req, e_keep, e_valid, e_fire, e_pop;

  always @(negedge clk) begin
    if (!rst) begin
      m_occ      = 0;
      m_inflight = 0;
      m_discard  = 0;
      m_fetch    = RESET_PC;
      m_dec      = RESET_PC;
      mem_q.delete();
      nxt_v      = 1'b0;
      nxt_d      = '0;
    end else begin
      cyc++;
      e_req   = !redirect_valid && (m_inflight + m_occ < DEPTH);
      e_keep  = imem_bus.imem_rsp_valid && !redirect_valid && (m_discard == 0);
      e_valid = (m_occ > 0) || (BYP && e_keep);

      check("req_valid", 32'(imem_bus.imem_req_valid), 32'(e_req));
      if (e_req) check("req_addr", imem_bus.imem_req_addr, m_fetch);
      check("valid_d", 32'(valid_d), 32'(e_valid));
      if (e_valid) begin
        check("pc_d", pc_d, m_dec);
        check("instr_d", instr_d, mem_word(m_dec));
        check("pcplus4_d", pcplus4_d, m_dec + 32'd4);
      end else begin
        check("instr_d_nop", instr_d, NOP_INSTR);
      end

      e_fire = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
      e_pop  = e_valid && !stall_d && !redirect_valid;
      if (redirect_valid) begin
        m_fetch   = {redirect_pc[31:2], 2'b00};
        m_dec     = {redirect_pc[31:2], 2'b00};
        m_occ     = 0;
        m_discard = m_inflight - (imem_bus.imem_rsp_valid ? 1 : 0);
      end else begin
        if (e_fire) m_fetch = m_fetch + 32'd4;
        if (imem_bus.imem_rsp_valid && m_discard > 0) m_discard--;
        m_occ = m_occ + (e_keep ? 1 : 0) - (e_pop ? 1 : 0);
        if (e_pop) m_dec = m_dec + 32'd4;
      end
      m_inflight = m_inflight + (e_fire ? 1 : 0) - (imem_bus.imem_rsp_valid ? 1 : 0);

      if (e_fire) mem_q.push_back('{due: cyc + mem_lat, data: mem_word(imem_bus.imem_req_addr)});
      nxt_v = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due == cyc + 1) begin
        nxt_v = 1'b1;
        nxt_d = mem_q[0].data;
        void'(mem_q.pop_front());
      end
    end
  end

  // Memory response driver; resets together with the DUT.
  initial begin
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (rst) #1;
      if (rst) begin
        imem_bus.imem_rsp_valid = nxt_v;
        imem_bus.imem_rsp_data  = nxt_d;
      end else begin
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] rdy_pat = 32'b1011_0111_1101_1110_0110_1111_1010_1101;
  logic [31:0] stl_pat = 32'b0001_1000_0110_0000_1110_0001_0000_0110;
  logic [31:0] got_pc [3];
  int          n_got;
  bit          seen;

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall_d        = 1'b0;
    imem_bus.imem_req_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    check("reset_valid_d", 32'(valid_d), 0);
    check("reset_instr_d", instr_d, 32'h0000_0013);
    check("reset_pc_d", pc_d, 0);
    check("reset_pcplus4_d", pcplus4_d, 4);
    check("reset_req_valid", 32'(imem_bus.imem_req_valid), 0);

    // First fetches: addresses 0,4,8 and the first instruction on cycle 3 (2 with bypass).
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("c1_req_valid", 32'(imem_bus.imem_req_valid), 1);
    check("c1_req_addr", imem_bus.imem_req_addr, 32'h0);
    check("c1_valid_d", 32'(valid_d), 0);
    @(negedge clk);
    check("c2_req_addr", imem_bus.imem_req_addr, 32'h4);
    check("c2_valid_d", 32'(valid_d), 32'(BYP));
    @(negedge clk);
    check("c3_req_addr", imem_bus.imem_req_addr, 32'h8);
    check("c3_valid_d", 32'(valid_d), 1);
    check("c3_pc_d", pc_d, BYP ? 32'h4 : 32'h0);
    repeat (5) tick();

    // Decode stall: requests stop once DEPTH entries are held.
    stall_d = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("stall_req_stopped", 32'(imem_bus.imem_req_valid), 0);
    check("stall_valid_d", 32'(valid_d), 1);
    tick();
    stall_d = 1'b0;
    repeat (8) tick();

    // Redirect against a full, stalled queue: the flush wins.
    stall_d = 1'b1;
    repeat (8) tick();
    mem_lat        = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_valid_d", 32'(valid_d), 0);
    check("flush_req_addr", imem_bus.imem_req_addr, 32'h200);

    // Three requests in flight, then redirect to 0x100: all three dropped.
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    stall_d        = 1'b0;
    tick();
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (valid_d) seen = 1'b1;
    end
    check("redir_seen", 32'(seen), 1);
    check("redir_pc_d", pc_d, 32'h100);
    check("redir_instr_d", instr_d, mem_word(32'h100));

    // Misaligned target is word-aligned.
    stall_d = 1'b1;
    repeat (12) tick();
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    stall_d        = 1'b0;
    @(negedge clk);
    check("align_req_addr", imem_bus.imem_req_addr, 32'h100);
    repeat (6) tick();

    // Address wrap at the top of the space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    n_got = 0;
    for (int k = 0; k < 40 && n_got < 3; k++) begin
      @(negedge clk);
      if (valid_d && !stall_d) begin
        got_pc[n_got] = pc_d;
        n_got++;
      end
    end
    check("wrap_count", n_got, 3);
    check("wrap_pc0", got_pc[0], 32'hFFFF_FFF8);
    check("wrap_pc1", got_pc[1], 32'hFFFF_FFFC);
    check("wrap_pc2", got_pc[2], 32'h0000_0000);

    // Mixed ready/stall pattern with a redirect in the middle.
    for (int i = 0; i < 32; i++) begin
      imem_bus.imem_req_ready = rdy_pat[i];
      stall_d                 = stl_pat[i];
      redirect_valid          = (i == 16);
      redirect_pc             = 32'h0000_0040;
      tick();
    end
    imem_bus.imem_req_ready = 1'b1;
    stall_d                 = 1'b0;
    redirect_valid          = 1'b0;
    repeat (3) tick();

    // Asynchronous reset in the middle of a burst.
    #2 rst = 1'b0;
    #1;
    check("midrst_valid_d", 32'(valid_d), 0);
    check("midrst_instr_d", instr_d, 32'h0000_0013);
    check("midrst_pc_d", pc_d, 0);
    check("midrst_pcplus4_d", pcplus4_d, 4);
    check("midrst_req_valid", 32'(imem_bus.imem_req_valid), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("restart_req_valid", 32'(imem_bus.imem_req_valid), 1);
    check("restart_req_addr", imem_bus.imem_req_addr, RESET_PC);
    @(negedge clk);
    @(negedge clk);
    check("restart_pc_d", pc_d, BYP ? RESET_PC + 32'd4 : RESET_PC);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
